// File: rtl/fetch_sequencer.sv
// Instruction-cycle sequencer: owns the step counter and program counter,
// selects the memory read address per step and captures the instruction word.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter bit          HALT_ENABLE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_ready,
    input  logic [15:0] memory_in,
    input  logic [15:0] immediate_read_address,
    input  logic [15:0] operand_address,
    input  logic [15:0] pc_next,
    input  logic        pc_write,
    input  logic        halt_request,
    input  logic        can_halt,
    input  logic        resume,
    output logic [1:0]  step,
    output logic        step_advance,
    output logic [15:0] pc,
    output logic [15:0] instruction,
    output logic [15:0] read_address,
    output logic        halted
);

    typedef enum logic [2:0] {
        FETCH_INSTR = 3'd0,
        FETCH_IMM   = 3'd1,
        OPERAND     = 3'd2,
        EXECUTE     = 3'd3,
        HALTED      = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  step_r, step_s;
    logic [15:0] pc_r, pc_s;
    logic [15:0] instr_r, instr_s;
    logic        halted_r, halted_s;
    logic        halt_take_s;
    logic [15:0] pc_plus2_s;

    assign halt_take_s = HALT_ENABLE && halt_request && can_halt;
    assign pc_plus2_s  = pc_r + 16'd2;

    // Next-state logic: each step waits for mem_ready; HALTED waits for resume.
    always_comb begin
        state_s  = state_r;
        step_s   = step_r;
        pc_s     = pc_r;
        instr_s  = instr_r;
        halted_s = halted_r;
        case (state_r)
            FETCH_INSTR: begin
                if (mem_ready) begin
                    instr_s = memory_in;
                    state_s = FETCH_IMM;
                    step_s  = 2'd1;
                end else begin
                    state_s = FETCH_INSTR;
                end
            end
            FETCH_IMM: begin
                if (mem_ready) begin
                    state_s = OPERAND;
                    step_s  = 2'd2;
                end else begin
                    state_s = FETCH_IMM;
                end
            end
            OPERAND: begin
                if (mem_ready) begin
                    state_s = EXECUTE;
                    step_s  = 2'd3;
                end else begin
                    state_s = OPERAND;
                end
            end
            EXECUTE: begin
                // A halt outranks a taken branch; pc keeps pointing at the halt.
                if (mem_ready) begin
                    step_s = 2'd0;
                    if (halt_take_s) begin
                        state_s  = HALTED;
                        halted_s = 1'b1;
                    end else if (pc_write) begin
                        state_s = FETCH_INSTR;
                        pc_s    = pc_next;
                    end else begin
                        state_s = FETCH_INSTR;
                        pc_s    = pc_plus2_s;
                    end
                end else begin
                    state_s = EXECUTE;
                end
            end
            HALTED: begin
                if (resume) begin
                    state_s  = FETCH_INSTR;
                    step_s   = 2'd0;
                    halted_s = 1'b0;
                    pc_s     = pc_plus2_s;
                end else begin
                    state_s = HALTED;
                end
            end
            default: begin
                state_s  = FETCH_INSTR;
                step_s   = 2'd0;
                halted_s = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset that overrides all other inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= FETCH_INSTR;
            step_r   <= 2'd0;
            pc_r     <= RESET_PC;
            instr_r  <= 16'h0000;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            step_r   <= step_s;
            pc_r     <= pc_s;
            instr_r  <= instr_s;
            halted_r <= halted_s;
        end
    end

    // Memory address mux by step.
    always_comb begin
        read_address = pc_r;
        case (state_r)
            FETCH_INSTR: read_address = pc_r;
            FETCH_IMM:   read_address = immediate_read_address;
            OPERAND:     read_address = operand_address;
            EXECUTE:     read_address = pc_r;
            HALTED:      read_address = pc_r;
            default:     read_address = pc_r;
        endcase
    end

    assign step_advance = mem_ready && !halted_r;
    assign step         = step_r;
    assign pc           = pc_r;
    assign instruction  = instr_r;
    assign halted       = halted_r;

endmodule
